// File: rtl/fetch_unit_if.sv
// Bundles the ROM bus and the instruction handshake between the fetch unit and its neighbours.
interface fetch_unit_if;
  logic [7:0] address;
  logic [7:0] from_memory;
  logic       instr_valid;
  logic       instr_ready;
  logic       br_taken;
  logic [7:0] br_target;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic [7:0] pc_out;
  logic       illegal;
  logic       fetch_fault;

  modport master (
    output address,
    input  from_memory,
    output instr_valid,
    input  instr_ready,
    input  br_taken,
    input  br_target,
    output opcode,
    output operand,
    output pc_out,
    output illegal,
    output fetch_fault
  );

  modport slave (
    input  address,
    output from_memory,
    input  instr_valid,
    output instr_ready,
    output br_taken,
    output br_target,
    input  opcode,
    input  operand,
    input  pc_out,
    input  illegal,
    input  fetch_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetches 1- or 2-byte instructions from a synchronous 128x8 ROM and presents them
// with a valid/ready handshake; branches are applied when an instruction is accepted.
module fetch_unit (
  input logic         clk,
  input logic         reset,
  fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    OP_REQ,
    OP_WAIT,
    OP_CAP,
    ARG_WAIT,
    ARG_CAP,
    DONE
  } state_t;

  state_t     state;
  logic [7:0] pc;
  logic [7:0] address;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic [7:0] pc_out;
  logic       illegal;
  logic       fetch_fault;
  logic       two_byte;
  logic       legal_one_byte;
  logic [7:0] pc_next;

  assign two_byte       = ((bus.from_memory >= 8'h10) && (bus.from_memory <= 8'h15)) ||
                          ((bus.from_memory >= 8'h30) && (bus.from_memory <= 8'h38));
  assign legal_one_byte = (bus.from_memory >= 8'h20) && (bus.from_memory <= 8'h27);
  assign pc_next        = pc + 8'd1;

  // The ROM needs one edge to latch the address, so every byte costs a request/wait/capture step.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= OP_REQ;
      pc          <= 8'h00;
      address     <= 8'h00;
      opcode      <= 8'h00;
      operand     <= 8'h00;
      pc_out      <= 8'h00;
      illegal     <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        OP_REQ: begin
          address     <= pc;
          pc_out      <= pc;
          illegal     <= 1'b0;
          fetch_fault <= 1'b0;
          state       <= OP_WAIT;
        end
        OP_WAIT: begin
          state <= OP_CAP;
        end
        OP_CAP: begin
          opcode      <= bus.from_memory;
          pc          <= pc_next;
          illegal     <= !(two_byte || legal_one_byte);
          fetch_fault <= pc[7];
          if (two_byte) begin
            address <= pc_next;
            state   <= ARG_WAIT;
          end else begin
            operand <= 8'h00;
            state   <= DONE;
          end
        end
        ARG_WAIT: begin
          state <= ARG_CAP;
        end
        ARG_CAP: begin
          operand     <= bus.from_memory;
          pc          <= pc_next;
          fetch_fault <= fetch_fault | pc[7];
          state       <= DONE;
        end
        DONE: begin
          // Branch info is only meaningful on the accepting edge.
          if (bus.instr_ready) begin
            pc    <= bus.br_taken ? bus.br_target : pc;
            state <= OP_REQ;
          end
        end
        default: begin
          state <= OP_REQ;
        end
      endcase
    end
  end

  assign bus.instr_valid = (state == DONE);
  assign bus.address     = address;
  assign bus.opcode      = opcode;
  assign bus.operand     = operand;
  assign bus.pc_out      = pc_out;
  assign bus.illegal     = illegal;
  assign bus.fetch_fault = fetch_fault;

endmodule
